sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of sprite-layer requesters.
REQ-002 The block SHALL have parameter ADDR_W, default 10: sprite ROM address width (32x32 sprite).
REQ-003 The block SHALL have parameter DATA_W, default 16: RGB565 pixel width.
REQ-004 The block SHALL have parameter MAX_BURST, default 32: maximum beats per grant (one sprite row).
REQ-005 The block SHALL have port clk  input  1  system clock, 50 MHz pixel-domain clock.
REQ-006 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-007 The block SHALL have port req  input  NUM_REQ  per-requester fetch request, level.
REQ-008 The block SHALL have port req_addr  input  NUM_REQ*ADDR_W  packed per-requester ROM address, requester i at slice [i*ADDR_W +: ADDR_W].
REQ-009 The block SHALL have port frame_start  input  1  one-cycle pulse at start of frame.
REQ-010 The block SHALL have port gnt  output  NUM_REQ  one-hot registered grant.
REQ-011 The block SHALL have port rom_addr  output  ADDR_W  address to the shared synchronous sprite ROM.
REQ-012 The block SHALL have port rom_data  input  DATA_W  ROM read data, valid one cycle after address.
REQ-013 The block SHALL have port rsp_valid  output  NUM_REQ  one-hot response strobe.
REQ-014 The block SHALL have port rsp_data  output  DATA_W  response pixel, equal to rom_data.
REQ-015 The block SHALL have port busy  output  1  high while any grant is held.

Function
REQ-016 The block SHALL implement states IDLE and BURST; gnt SHALL be all-zero in IDLE and exactly one-hot in BURST.
REQ-017 IDLE->BURST: when any req bit is high, the picked requester's gnt bit SHALL be high on the next cycle.
REQ-018 The pick SHALL be round-robin: search starts at (last_granted+1) mod NUM_REQ, ascending with wrap.
REQ-019 A beat SHALL be any cycle with gnt[i]=1 and req[i]=1; in that cycle rom_addr SHALL equal req_addr slice i.
REQ-020 rom_addr SHALL be 0 in any cycle that is not a beat.
REQ-021 rsp_valid[i] SHALL be high exactly one cycle after each beat of requester i; latency from beat to data is 1 cycle.
REQ-022 A 6-bit (clog2(MAX_BURST)+1) beat counter SHALL clear on each new grant and increment on each beat.
REQ-023 The grant SHALL end after the beat on which the counter reaches MAX_BURST, or in a cycle where req[i]=0 while gnt[i]=1 (no beat that cycle).
REQ-024 At grant end, the block SHALL re-pick among the other requesters, excluding the ending one, and assign the next grant on the following cycle with no idle gap; if none requests, the block SHALL go to IDLE.
REQ-025 A requester ended by the burst limit SHALL regain the grant only when it is the round-robin pick.
REQ-026 frame_start SHALL set last_granted to NUM_REQ-1 so requester 0 has top priority at the next pick; it SHALL NOT abort a burst in progress.
REQ-027 frame_start coincident with a pick SHALL apply to that same pick.
REQ-028 busy SHALL equal |gnt.

Reset
REQ-029 While reset is high, the block SHALL hold state IDLE, gnt=0, rsp_valid=0, rom_addr=0, busy=0, counter=0, and last_granted=NUM_REQ-1.
REQ-030 Reset asserted mid-burst SHALL drop gnt immediately; no rsp_valid SHALL follow for beats in flight.
REQ-031 Requests SHALL be evaluated from the first clock edge after reset deasserts.

Structure
REQ-032 Package sprite_pkg SHALL hold NUM_REQ, ADDR_W, DATA_W, MAX_BURST defaults and the arb_state_t enum (IDLE, BURST).
REQ-033 Round-robin selection SHALL be the combinational sub-module rr_pick (inputs: request vector, last index; outputs: valid, index).
REQ-034 The response tag SHALL be one NUM_REQ-bit register aligned with ROM latency.

Verification
REQ-035 Single requester: req=0001 with addresses 0..31, held -> gnt[0] from cycle 1, 32 beats, rsp_valid[0] on cycles 2..33 with rsp_data=ROM[0..31], then IDLE.
REQ-036 All four requesting continuously -> grants 0,1,2,3,0, 32 beats each, no gap cycles between grants.
REQ-037 req[2] drops after 5 beats while req[3]=1 -> gnt switches to 3 on the next cycle; exactly 5 rsp_valid[2] pulses.
REQ-038 Grant at requester 2, frame_start pulse mid-burst, req=1111 -> burst completes, next grant goes to 0.
REQ-039 Reset asserted on beat 10 -> gnt=0, rsp_valid=0 next cycle; after release, req=0010 -> gnt[1] one cycle later.
REQ-040 No requests for 100 cycles -> gnt=0, rom_addr=0, rsp_valid=0, busy=0 throughout.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared defaults and types for the sprite ROM arbiter.
// The defaults fit 4 sprite layers reading 32x32 RGB565 sprites, one row per grant.
package sprite_pkg;

    localparam int NUM_REQ_DEFAULT   = 4;
    localparam int ADDR_W_DEFAULT    = 10;
    localparam int DATA_W_DEFAULT    = 16;
    localparam int MAX_BURST_DEFAULT = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker.
// The search starts one past i_last and wraps, so the most recent winner is tried last.
module rr_pick
    import sprite_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int IDX_W   = idxWidth(NUM_REQ_DEFAULT)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    always_comb begin
        int j;
        o_valid = 1'b0;
        o_idx   = '0;
        j       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(i_last) + k) % NUM_REQ;
            if (!o_valid && i_req[j]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one synchronous sprite ROM between several sprite layers.
// Each grant lasts up to MAX_BURST beats; responses come back one cycle after each beat.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEFAULT,
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic                      frame_start,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    localparam int IDX_W = idxWidth(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_rspTag;
    logic [IDX_W-1:0]   r_last;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_beat;
    logic               w_burstEnd;
    logic               w_doPick;
    logic [NUM_REQ-1:0] w_pickReq;
    logic [IDX_W-1:0]   w_lastEff;
    logic               w_pickValid;
    logic [IDX_W-1:0]   w_pickIdx;
    logic [ADDR_W-1:0]  w_romAddr;

    assign w_beat     = |(r_gnt & req);
    assign w_burstEnd = (r_state == BURST) &&
                        (!w_beat || (r_cnt == CNT_W'(MAX_BURST - 1)));
    assign w_doPick   = (r_state == IDLE) || w_burstEnd;
    // The ending requester is masked out so a full burst hands the ROM to someone else.
    assign w_pickReq  = (r_state == IDLE) ? req : (req & ~r_gnt);
    assign w_lastEff  = frame_start ? LAST_IDX : r_last;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rrPick (
        .i_req   (w_pickReq),
        .i_last  (w_lastEff),
        .o_valid (w_pickValid),
        .o_idx   (w_pickIdx)
    );

    always_comb begin
        w_romAddr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt[i] && req[i]) begin
                w_romAddr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_rspTag <= '0;
            r_last   <= LAST_IDX;
            r_cnt    <= '0;
        end else begin
            r_rspTag <= r_gnt & req;
            if (w_doPick) begin
                r_cnt <= '0;
                if (w_pickValid) begin
                    r_state <= BURST;
                    r_gnt   <= NUM_REQ'(1) << w_pickIdx;
                    r_last  <= w_pickIdx;
                end else begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_last  <= w_lastEff;
                end
            end else begin
                if (w_beat) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                // A frame pulse mid-burst only rewinds priority; the burst itself continues.
                if (frame_start) begin
                    r_last <= LAST_IDX;
                end
            end
        end
    end

    assign gnt       = r_gnt;
    assign rom_addr  = w_romAddr;
    assign rsp_valid = r_rspTag;
    assign rsp_data  = rom_data;
    assign busy      = |r_gnt;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a behavioural synchronous ROM.
// Each applyStimulus call advances one clock and drives that cycle's inputs.
module tb_sprite_rom_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [39:0] req_addr;
    logic        frame_start;
    logic [3:0]  gnt;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;

    int total;
    int bad;

    sprite_rom_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_addr    (req_addr),
        .frame_start (frame_start),
        .gnt         (gnt),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] romVal(input logic [9:0] a);
        return 16'(a) * 16'd37 + 16'h1234;
    endfunction

    function automatic logic [39:0] packAddr(input logic [9:0] a0, input logic [9:0] a1,
                                             input logic [9:0] a2, input logic [9:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Behavioural synchronous ROM: data appears one cycle after the address.
    always @(posedge clk) rom_data <= romVal(rom_addr);

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [39:0] a, input logic fs);
        @(posedge clk);
        #2;
        req         = r;
        req_addr    = a;
        frame_start = fs;
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_gnt"}, 64'(gnt), 64'h0);
        checkOutput({tag, "_rsp"}, 64'(rsp_valid), 64'h0);
        checkOutput({tag, "_addr"}, 64'(rom_addr), 64'h0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'h0);
    endtask

    initial begin
        logic [9:0]  addrs [4];
        logic [39:0] allAddr;
        int          seqIdx [5];
        logic [3:0]  prevExp;
        int          prevIdx;
        int          pulses2;

        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        req         = '0;
        req_addr    = '0;
        frame_start = 1'b0;
        addrs[0] = 10'd5;
        addrs[1] = 10'd200;
        addrs[2] = 10'd513;
        addrs[3] = 10'd1000;
        allAddr  = packAddr(addrs[0], addrs[1], addrs[2], addrs[3]);

        repeat (3) @(posedge clk);
        #2;
        checkIdle("reset");
        reset = 1'b0;

        // Single requester, addresses 0..31, one full row then idle.
        applyStimulus(4'b0001, packAddr(10'd0, 10'd0, 10'd0, 10'd0), 1'b0);
        checkOutput("t1_c0_gnt", 64'(gnt), 64'h0);
        for (int k = 1; k <= 32; k++) begin
            applyStimulus(4'b0001, packAddr(10'(k - 1), 10'd0, 10'd0, 10'd0), 1'b0);
            checkOutput("t1_gnt", 64'(gnt), 64'h1);
            checkOutput("t1_addr", 64'(rom_addr), 64'(k - 1));
            checkOutput("t1_busy", 64'(busy), 64'h1);
            if (k == 1) begin
                checkOutput("t1_rsp_first", 64'(rsp_valid), 64'h0);
            end else begin
                checkOutput("t1_rsp", 64'(rsp_valid), 64'h1);
                checkOutput("t1_data", 64'(rsp_data), 64'(romVal(10'(k - 2))));
            end
        end
        applyStimulus(4'b0000, '0, 1'b0);
        checkOutput("t1_end_gnt", 64'(gnt), 64'h0);
        checkOutput("t1_end_rsp", 64'(rsp_valid), 64'h1);
        checkOutput("t1_end_data", 64'(rsp_data), 64'(romVal(10'd31)));
        applyStimulus(4'b0000, '0, 1'b0);
        checkIdle("t1_idle");

        // All four requesting, frame pulse on the first pick: grants 0,1,2,3,0 back to back.
        seqIdx[0] = 0; seqIdx[1] = 1; seqIdx[2] = 2; seqIdx[3] = 3; seqIdx[4] = 0;
        applyStimulus(4'b1111, allAddr, 1'b1);
        checkOutput("t2_c0_gnt", 64'(gnt), 64'h0);
        prevExp = 4'b0000;
        prevIdx = 0;
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 32; b++) begin
                applyStimulus(4'b1111, allAddr, 1'b0);
                checkOutput("t2_gnt", 64'(gnt), 64'(4'b0001 << seqIdx[g]));
                checkOutput("t2_addr", 64'(rom_addr), 64'(addrs[seqIdx[g]]));
                checkOutput("t2_rsp", 64'(rsp_valid), 64'(prevExp));
                if (prevExp != 4'b0000) begin
                    checkOutput("t2_data", 64'(rsp_data), 64'(romVal(addrs[prevIdx])));
                end
                prevExp = 4'b0001 << seqIdx[g];
                prevIdx = seqIdx[g];
            end
        end
        // Requests vanish just as requester 1 is granted: a no-beat cycle then idle.
        applyStimulus(4'b0000, allAddr, 1'b0);
        checkOutput("t2_nobeat_gnt", 64'(gnt), 64'h2);
        checkOutput("t2_nobeat_addr", 64'(rom_addr), 64'h0);
        checkOutput("t2_nobeat_rsp", 64'(rsp_valid), 64'h1);
        applyStimulus(4'b0000, allAddr, 1'b0);
        checkIdle("t2_idle");

        // Requester 2 drops after 5 beats while requester 3 waits.
        pulses2 = 0;
        applyStimulus(4'b1100, allAddr, 1'b0);
        for (int b = 1; b <= 5; b++) begin
            applyStimulus(4'b1100, allAddr, 1'b0);
            checkOutput("t3_gnt2", 64'(gnt), 64'h4);
            checkOutput("t3_addr2", 64'(rom_addr), 64'(addrs[2]));
            if (rsp_valid[2]) pulses2++;
        end
        applyStimulus(4'b1000, allAddr, 1'b0);
        checkOutput("t3_drop_gnt", 64'(gnt), 64'h4);
        checkOutput("t3_drop_addr", 64'(rom_addr), 64'h0);
        if (rsp_valid[2]) pulses2++;
        applyStimulus(4'b1000, allAddr, 1'b0);
        checkOutput("t3_sw_gnt", 64'(gnt), 64'h8);
        checkOutput("t3_sw_addr", 64'(rom_addr), 64'(addrs[3]));
        checkOutput("t3_sw_rsp", 64'(rsp_valid), 64'h0);
        if (rsp_valid[2]) pulses2++;
        applyStimulus(4'b0000, allAddr, 1'b0);
        checkOutput("t3_rsp3", 64'(rsp_valid), 64'h8);
        if (rsp_valid[2]) pulses2++;
        checkOutput("t3_pulses2", 64'(pulses2), 64'd5);
        applyStimulus(4'b0000, allAddr, 1'b0);
        checkIdle("t3_idle");

        // Grant at 2, frame pulse mid-burst: burst completes and 0 wins next.
        applyStimulus(4'b0100, allAddr, 1'b0);
        for (int b = 1; b <= 32; b++) begin
            applyStimulus(4'b1111, allAddr, (b == 10));
            checkOutput("t4_gnt2", 64'(gnt), 64'h4);
        end
        applyStimulus(4'b0000, allAddr, 1'b0);
        checkOutput("t4_next_gnt", 64'(gnt), 64'h1);
        checkOutput("t4_next_rsp", 64'(rsp_valid), 64'h4);
        applyStimulus(4'b0000, allAddr, 1'b0);
        checkIdle("t4_idle");

        // Reset on beat 10 drops everything at once; requester 1 granted right after release.
        applyStimulus(4'b0001, allAddr, 1'b0);
        for (int b = 1; b <= 10; b++) begin
            applyStimulus(4'b0001, allAddr, 1'b0);
            checkOutput("t5_gnt0", 64'(gnt), 64'h1);
        end
        reset = 1'b1;
        #1;
        checkIdle("t5_rst");
        applyStimulus(4'b0001, allAddr, 1'b0);
        checkIdle("t5_rst_next");
        reset = 1'b0;
        req   = 4'b0010;
        applyStimulus(4'b0010, allAddr, 1'b0);
        checkOutput("t5_gnt1", 64'(gnt), 64'h2);
        checkOutput("t5_addr1", 64'(rom_addr), 64'(addrs[1]));
        checkOutput("t5_rsp_none", 64'(rsp_valid), 64'h0);
        applyStimulus(4'b0000, allAddr, 1'b0);
        checkOutput("t5_rsp1", 64'(rsp_valid), 64'h2);
        checkOutput("t5_data1", 64'(rsp_data), 64'(romVal(addrs[1])));
        applyStimulus(4'b0000, allAddr, 1'b0);
        checkIdle("t5_idle");

        // Long quiet stretch with no requests.
        for (int c = 0; c < 100; c++) begin
            applyStimulus(4'b0000, allAddr, 1'b0);
            checkIdle("t6_quiet");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
